// File: rtl/systolic_pkg.sv
// Shared defaults and FSM encoding for the systolic array output drain.
// Pure declarations; no logic, latency or flow control of its own.
package systolic_pkg;
  localparam int N       = 4;
  localparam int DATA_W  = 32;
  localparam int SCALE_W = 32;
  localparam int SHIFT   = 16;
  localparam int OUT_W   = 8;

  typedef enum logic [2:0] {IDLE, COLLECT, QUANT, DRAIN, DONE} drain_state_t;
endpackage

// File: rtl/requant_unit.sv
// Requantizes one signed psum to OUT_W bits (scale, round-half-up, saturate), one cycle latency.
// Accepts a new element every cycle; no backpressure.
module requant_unit #(
  parameter int DATA_W  = 32,
  parameter int SCALE_W = 32,
  parameter int SHIFT   = 16,
  parameter int OUT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DATA_W-1:0]  psum,
  input  logic [SCALE_W-1:0] scale,
  output logic [OUT_W-1:0]   q
);
  localparam int P_W = DATA_W + SCALE_W + 1;
  localparam logic signed [P_W-1:0] SAT_HI = P_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [P_W-1:0] SAT_LO = ~SAT_HI;

  logic signed [P_W-1:0] a_ext, s_ext, prod, rnd, r;
  logic [OUT_W-1:0] q_nxt;

  // Full-width product: scale is zero-extended so it is always non-negative.
  assign a_ext = {{(SCALE_W + 1){psum[DATA_W-1]}}, psum};
  assign s_ext = {{(DATA_W + 1){1'b0}}, scale};
  assign prod  = a_ext * s_ext;

  generate
    if (SHIFT > 0) begin : g_round
      localparam logic signed [P_W-1:0] HALF = P_W'(1) << (SHIFT - 1);
      assign rnd = prod + HALF;
    end else begin : g_noround
      assign rnd = prod;
    end
  endgenerate

  assign r = rnd >>> SHIFT;

  always_comb begin
    q_nxt = r[OUT_W-1:0];
    if (r > SAT_HI)      q_nxt = SAT_HI[OUT_W-1:0];
    else if (r < SAT_LO) q_nxt = SAT_LO[OUT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) q <= '0;
    else     q <= q_nxt;
  end
endmodule

// File: rtl/systolic_output_drain.sv
// Deskews column psums into a tile buffer, requantizes to int8, streams rows; N*N+2 cycles last strobe to first word.
// Output rows hold stable while res_ready is low; column strobes are never stalled (excess strobes flag err_overflow).
module systolic_output_drain #(
  parameter int N       = systolic_pkg::N,
  parameter int DATA_W  = systolic_pkg::DATA_W,
  parameter int SCALE_W = systolic_pkg::SCALE_W,
  parameter int SHIFT   = systolic_pkg::SHIFT,
  parameter int OUT_W   = systolic_pkg::OUT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [SCALE_W-1:0]    layer_scale,
  input  logic [N-1:0]          col_valid,
  input  logic [N*DATA_W-1:0]   col_data,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [N*OUT_W-1:0]    res_data,
  output logic                  res_last,
  output logic                  busy,
  output logic                  done,
  output logic                  err_overflow
);
  import systolic_pkg::*;

  localparam int IDX_W = $clog2(N);
  localparam int CNT_W = $clog2(N + 1);
  localparam int E_W   = $clog2(N * N + 1);

  drain_state_t       state, state_nxt;
  logic [CNT_W-1:0]   col_cnt [N];
  logic [N-1:0]       col_full_nxt;
  logic [DATA_W-1:0]  psum [N][N];
  logic [OUT_W-1:0]   obuf [N][N];
  logic [SCALE_W-1:0] scale_r;
  logic [E_W-1:0]     e_idx;
  logic [2*IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0]   w_idx;
  logic [OUT_W-1:0]   q;
  logic               start_acc, hs;

  assign start_acc = start && (state == IDLE);
  assign hs        = res_valid && res_ready;

  // Look ahead one strobe so QUANT begins the cycle right after the final column fills.
  always_comb begin
    col_full_nxt = '0;
    for (int j = 0; j < N; j++)
      col_full_nxt[j] = (col_cnt[j] == CNT_W'(N)) ||
                        (col_valid[j] && (col_cnt[j] == CNT_W'(N - 1)));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_acc) state_nxt = COLLECT;
      COLLECT: if (&col_full_nxt) state_nxt = QUANT;
      QUANT:   if (e_idx == E_W'(N * N)) state_nxt = DRAIN;
      DRAIN:   if (hs && res_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < N; j++) col_cnt[j] <= '0;
      scale_r      <= '0;
      e_idx        <= '0;
      wr_idx       <= '0;
      w_idx        <= '0;
      err_overflow <= 1'b0;
    end else begin
      wr_idx <= e_idx[2*IDX_W-1:0];
      if (start_acc) begin
        for (int j = 0; j < N; j++) col_cnt[j] <= '0;
        scale_r      <= layer_scale;
        e_idx        <= '0;
        w_idx        <= '0;
        err_overflow <= 1'b0;
      end
      if (state == COLLECT) begin
        for (int j = 0; j < N; j++) begin
          if (col_valid[j]) begin
            if (col_cnt[j] == CNT_W'(N)) err_overflow <= 1'b1;
            else                         col_cnt[j] <= col_cnt[j] + CNT_W'(1);
          end
        end
      end
      if (state == QUANT) e_idx <= e_idx + E_W'(1);
      if (hs) w_idx <= w_idx + IDX_W'(1);
    end
  end

  // Tile storage is don't-care after reset, so it carries no reset.
  always_ff @(posedge clk) begin
    if (state == COLLECT) begin
      for (int j = 0; j < N; j++)
        if (col_valid[j] && (col_cnt[j] != CNT_W'(N)))
          psum[col_cnt[j][IDX_W-1:0]][j] <= col_data[j*DATA_W +: DATA_W];
    end
    if ((state == QUANT) && (e_idx != '0))
      obuf[wr_idx[2*IDX_W-1:IDX_W]][wr_idx[IDX_W-1:0]] <= q;
  end

  requant_unit #(
    .DATA_W (DATA_W),
    .SCALE_W(SCALE_W),
    .SHIFT  (SHIFT),
    .OUT_W  (OUT_W)
  ) u_requant (
    .clk  (clk),
    .rst  (rst),
    .psum (psum[e_idx[2*IDX_W-1:IDX_W]][e_idx[IDX_W-1:0]]),
    .scale(scale_r),
    .q    (q)
  );

  assign res_valid = (state == DRAIN);
  assign res_last  = res_valid && (w_idx == IDX_W'(N - 1));
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  always_comb begin
    res_data = '0;
    if (res_valid)
      for (int j = 0; j < N; j++) res_data[j*OUT_W +: OUT_W] = obuf[w_idx][j];
  end
endmodule

// File: tb/tb_systolic_output_drain.sv
// Randomized bench for systolic_output_drain: expected rows come from a plain-arithmetic requant model.
// A negedge monitor pops the scoreboard on every handshake and checks hold-stability under backpressure.
module tb_systolic_output_drain;
  localparam int N = 4;
  localparam int DATA_W = 32;
  localparam int SCALE_W = 32;
  localparam int OUT_W = 8;

  logic clk = 1'b0;
  logic rst, start, res_ready, res_valid, res_last, busy, done, err_overflow;
  logic [SCALE_W-1:0]  layer_scale;
  logic [N-1:0]        col_valid;
  logic [N*DATA_W-1:0] col_data;
  logic [N*OUT_W-1:0]  res_data;

  always #5 clk = ~clk;

  systolic_output_drain dut (
    .clk(clk), .rst(rst), .start(start), .layer_scale(layer_scale),
    .col_valid(col_valid), .col_data(col_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_last(res_last),
    .busy(busy), .done(done), .err_overflow(err_overflow)
  );

  typedef struct {
    logic [N*OUT_W-1:0] d;
    logic               last;
  } exp_t;

  exp_t exp_q[$];
  int n_cmp = 0, n_fail = 0;
  int acc_total = 0, done_cnt = 0, tile_base = 0, ready_mode = 0, stall_cyc = 0;
  logic               stall_pend = 1'b0;
  logic [N*OUT_W-1:0] held_d;
  logic               held_l;

  task automatic check(input bit ok, input string name, input longint act, input longint expv);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Real-valued meaning: round(psum * scale / 65536) with ties toward +inf, clamped to int8.
  function automatic logic [7:0] ref_q(input int p, input logic [31:0] s);
    longint prod, r;
    logic [7:0] res;
    prod = longint'(p) * longint'({32'b0, s});
    r = (prod + 64'sd32768) >>> 16;
    if (r > 127)       res = 8'h7f;
    else if (r < -128) res = 8'h80;
    else               res = r[7:0];
    return res;
  endfunction

  // Downstream ready generator: 0 always ready, 1 random, 2 stall 5 cycles on word 1, 4 stop after 2 words.
  initial begin
    res_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        1: res_ready = 1'($urandom_range(0, 1));
        2: begin
          if (res_valid && (acc_total - tile_base == 1) && stall_cyc < 5) begin
            res_ready = 1'b0;
            stall_cyc++;
          end else res_ready = 1'b1;
        end
        4: res_ready = (acc_total - tile_base < 2);
        default: begin
          res_ready = 1'b1;
          stall_cyc = 0;
        end
      endcase
    end
  end

  // Monitor: scoreboard pop on handshake, stability under stall, done pulse counting.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) stall_pend = 1'b0;
      else begin
        if (stall_pend)
          check(res_valid && res_data === held_d && res_last === held_l, "stall_hold",
                {res_valid, res_last, res_data}, {1'b1, held_l, held_d});
        if (res_valid && res_ready) begin
          check(exp_q.size() != 0, "unexpected_word", res_data, 0);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check(res_data === e.d && res_last === e.last, "word",
                  {res_last, res_data}, {e.last, e.d});
          end
          acc_total++;
        end
        stall_pend = res_valid && !res_ready;
        held_d = res_data;
        held_l = res_last;
        if (done) done_cnt++;
      end
    end
  end

  task automatic run_tile(input logic [31:0] scale, input int ps[N*N], input int extra_col,
                          input int rmode, input bit mid_reset);
    int rem[N], k[N];
    int cnt, t, base_done, left;
    logic [N-1:0] cv;
    logic [N*OUT_W-1:0] w;
    for (int r = 0; r < N; r++) begin
      w = '0;
      for (int c = 0; c < N; c++) w[c*OUT_W +: OUT_W] = ref_q(ps[r*N+c], scale);
      exp_q.push_back('{w, (r == N - 1)});
    end
    ready_mode = rmode;
    tile_base = acc_total;
    base_done = done_cnt;

    // Strobes in the start cycle must be ignored.
    start = 1'b1;
    layer_scale = scale;
    col_valid = '1;
    for (int j = 0; j < N; j++) col_data[j*DATA_W +: DATA_W] = $urandom;
    @(posedge clk); #1;
    start = 1'b0;
    col_valid = '0;
    check(err_overflow == 1'b0, "ovf_clear_on_start", err_overflow, 0);
    check(busy == 1'b1, "busy_after_start", busy, 1);

    left = 0;
    for (int j = 0; j < N; j++) begin
      rem[j] = N + ((j == extra_col) ? 1 : 0);
      k[j] = 0;
      left += rem[j];
    end
    while (left > 0) begin
      cv = '0;
      for (int j = 0; j < N; j++) begin
        if (rem[j] > 0 && (extra_col < 0 || j == extra_col || rem[extra_col] == 0) &&
            $urandom_range(0, 1) == 1) begin
          cv[j] = 1'b1;
          col_data[j*DATA_W +: DATA_W] = (k[j] < N) ? ps[k[j]*N+j] : $urandom;
          k[j]++;
          rem[j]--;
          left--;
        end
      end
      col_valid = cv;
      start = ($urandom_range(0, 7) == 0);
      layer_scale = $urandom;
      @(posedge clk); #1;
    end
    col_valid = '0;
    start = 1'b0;
    check(err_overflow == (extra_col >= 0), "err_overflow", err_overflow, extra_col >= 0);

    cnt = 1;
    while (!res_valid && cnt < 200) begin
      @(posedge clk); #1;
      cnt++;
    end
    check(cnt == N * N + 2, "latency", cnt, N * N + 2);

    if (mid_reset) begin
      t = 0;
      while (acc_total - tile_base < 2 && t < 500) begin
        @(posedge clk); #1;
        t++;
      end
      check(acc_total - tile_base == 2, "words_before_reset", acc_total - tile_base, 2);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check(res_valid == 1'b0 && busy == 1'b0, "reset_to_idle", {res_valid, busy}, 0);
      check(exp_q.size() == 2, "undelivered_after_reset", exp_q.size(), 2);
      exp_q.delete();
      repeat (3) begin @(posedge clk); #1; end
      check(done_cnt == base_done, "no_done_on_reset", done_cnt - base_done, 0);
    end else begin
      t = 0;
      while (done_cnt == base_done && t < 2000) begin
        @(posedge clk); #1;
        t++;
      end
      check(done_cnt == base_done + 1, "done_pulse", done_cnt - base_done, 1);
      repeat (3) begin @(posedge clk); #1; end
      check(done_cnt == base_done + 1, "done_once", done_cnt - base_done, 1);
      check(busy == 1'b0 && res_valid == 1'b0, "idle_after_done", {busy, res_valid}, 0);
      check(exp_q.size() == 0, "all_words_drained", exp_q.size(), 0);
      check(acc_total - tile_base == N, "word_count", acc_total - tile_base, N);
    end
    ready_mode = 0;
  endtask

  initial begin
    int ps[N*N];
    int pat[4];
    logic [31:0] sc;
    rst = 1'b1;
    start = 1'b0;
    layer_scale = '0;
    col_valid = '0;
    col_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check({res_valid, res_last, busy, done, err_overflow} == 5'b0, "reset_outputs",
          {res_valid, res_last, busy, done, err_overflow}, 0);
    check(res_data == '0, "reset_res_data", res_data, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Identity scale, ascending values.
    for (int i = 0; i < N*N; i++) ps[i] = i;
    run_tile(32'h10000, ps, -1, 0, 1'b0);

    // Saturation on both rails.
    pat = '{200, -300, 127, -128};
    for (int i = 0; i < N*N; i++) ps[i] = pat[i % 4];
    run_tile(32'h10000, ps, -1, 0, 1'b0);

    // Half scale exercises round-half-up on positive and negative ties.
    pat = '{3, -3, 1, -1};
    for (int i = 0; i < N*N; i++) ps[i] = pat[i % 4];
    run_tile(32'h8000, ps, -1, 0, 1'b0);

    // Backpressure on word 1.
    for (int i = 0; i < N*N; i++) ps[i] = int'($urandom_range(0, 400)) - 200;
    run_tile(32'h10000, ps, -1, 2, 1'b0);

    // Column 2 over-strobed; extra data must be dropped.
    for (int i = 0; i < N*N; i++) ps[i] = int'($urandom_range(0, 400)) - 200;
    run_tile(32'h10000, ps, 2, 0, 1'b0);

    // Reset in the middle of draining, then a clean tile.
    for (int i = 0; i < N*N; i++) ps[i] = int'($urandom_range(0, 400)) - 200;
    run_tile(32'h10000, ps, -1, 4, 1'b1);
    for (int i = 0; i < N*N; i++) ps[i] = int'($urandom_range(0, 400)) - 200;
    run_tile(32'h18000, ps, -1, 0, 1'b0);

    for (int n = 0; n < 10; n++) begin
      for (int i = 0; i < N*N; i++)
        ps[i] = ($urandom_range(0, 7) == 0) ? int'($urandom) : int'($urandom_range(0, 4000)) - 2000;
      sc = $urandom_range(0, 32'h30000);
      run_tile(sc, ps, -1, 1, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end
endmodule
